spi_ram_responder: RTL and testbench
====================================

Name: spi_ram_responder

Overview:
- SPI mode-0 responder that emulates a 23LC-style serial SRAM. It is the far end of the CPU's SPI memory port: CPU `spi_select`/`spi_clk`/`spi_mosi` drive this block, and `spi_miso` returns to the CPU.
- It oversamples the SPI pins in the system clock domain and implements READ (0x03) and WRITE (0x02) with a 16-bit address and sequential auto-increment.
- Used as an on-chip/FPGA memory stand-in and as the bench model for CPU bring-up.

Parameters:
- ADDR_W, 16, address bits sent on the wire; must be a multiple of 8.
- MEM_ADDR_W, 8, implemented storage address width. Depth = 2**MEM_ADDR_W bytes; upper wire-address bits are ignored (aliasing).
- SYNC_STAGES, 2, synchronizer flops on `spi_clk`/`spi_select`/`spi_mosi`; minimum 2.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- spi_clk, input, 1, SPI clock from initiator; idles low (mode 0).
- spi_select, input, 1, chip select, active low.
- spi_mosi, input, 1, initiator-to-responder data, MSB first.
- spi_miso, output, 1, responder-to-initiator data, MSB first.
- spi_miso_oe, output, 1, high while driving read data.
- active, output, 1, high from `spi_select` falling (synchronized) until it rises.

Behaviour:
- **Clock and reset:** one clock `clk`. Reset is async active-high and applies to all registers except the storage array.
- **Reset values:** spi_miso=0, spi_miso_oe=0, active=0, state=IDLE, bit/byte counters=0. Memory contents are not reset (undefined until written).
- **Synchronization:** all three SPI inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized `spi_clk`/`spi_select`.
- **Timing requirement:** each SPI clock phase must be ≥4 clk cycles. Performance below that is not required.
- **Sampling and shifting:** MOSI is sampled on the rising edge of `spi_clk`. MISO changes only on the falling edge of `spi_clk`, except for the preload described under READ.
- **States:** IDLE, CMD, ADDR, READ, WRITE, IGNORE.
- **IDLE:** on `spi_select` falling → CMD, clear counters, active=1.
- **CMD:** shift 8 bits. On the 8th rising edge, decode the command:
  - 0x03 → ADDR, read flag set.
  - 0x02 → ADDR, write flag set.
  - Anything else → IGNORE.
- **ADDR:** shift ADDR_W bits. On the last rising edge, latch `addr = wire_addr[MEM_ADDR_W-1:0]`.
  - If the read flag is set: load the shift register with mem[addr], then → READ.
  - If the write flag is set: → WRITE.
- **READ:**
  - spi_miso_oe=1; spi_miso = shift MSB.
  - On the first falling edge after the last address bit, present bit 7 of the loaded byte.
  - Each subsequent falling edge shifts left.
  - On the 8th rising edge of each data byte, addr = addr+1 mod 2**MEM_ADDR_W, and the next falling edge presents MSB of mem[new addr].
  - Wrap from the top of memory to 0 is seamless.
- **WRITE:**
  - On the 8th rising edge of each data byte, commit the byte to mem[addr], then addr = addr+1 mod depth.
  - A partial byte (<8 bits) at deselect is discarded; earlier full bytes remain committed.
- **IGNORE:** MOSI is discarded; spi_miso=0, oe=0.
- **Deselect:** `spi_select` rising (synchronized) in any state → IDLE within SYNC_STAGES+1 clk cycles. On return to IDLE: spi_miso=0, spi_miso_oe=0, active=0, and no pending write is committed.
- **Edge cases:**
  - `spi_clk` edges while `spi_select` is high are ignored.
  - `spi_select` falling while not IDLE (glitch-free re-select without a seen rise) cannot occur by construction; treat it as a restart to CMD.
  - Reset asserted mid-transaction aborts immediately with the reset values above; memory keeps prior contents.
- **Storage and latency:** storage is a register array with a combinational read. Latency from the last address bit to valid MISO is ≤2 clk after the falling edge is detected.

Optional Feature:
- Macro: SPI_RAM_MODE_REG_EN.
- **With the macro defined:** adds an 8-bit mode register, reset value 0x40 (sequential).
  - Command 0x01 (WRMR): the next byte is written to the mode register; then → IGNORE.
  - Command 0x05 (RDMR): returns the mode register repeatedly, on every byte, until deselect.
  - Mode[7:6]=00 (byte mode): after one data byte, READ/WRITE → IGNORE (no auto-increment beyond that byte).
  - Mode[7:6]=01 or any other value: sequential operation.
- **Without the macro:** 0x01/0x05 are unknown commands (→ IGNORE), and operation is always sequential.

Test Plan:
- Reset mid-WRITE, then select with 0x03 0x0000 and clock 8 bits → spi_miso_oe=1, active=1; after deselect, spi_miso=0, oe=0, active=0.
- WRITE 0x02, addr 0x0010, data 0xA5 0x3C; then READ 0x03 0x0010 and clock 16 bits → MISO bytes 0xA5, 0x3C.
- Wrap: WRITE addr 0x00FF, data 0x11 0x22; READ 0x0000 → 0x22; READ 0x00FF → 0x11. Also READ addr 0x01FF → 0x11 (alias).
- Partial write: WRITE addr 0x0020, data 0x77 then 5 bits, deselect → mem[0x20]=0x77, mem[0x21] unchanged.
- Unknown command 0x9F, 24 clocks → spi_miso_oe stays 0, memory unchanged.
- With SPI_RAM_MODE_REG_EN: RDMR after reset → 0x40. WRMR 0x00, then READ 0x0010 for 16 bits → first byte 0xA5, oe drops to 0 after byte 1.

Source files
------------

// File: rtl/spi_ram_responder.sv
// rtl/spi_ram_responder.sv - SPI mode-0 serial SRAM responder (23LC-style READ/WRITE)
//
// Purpose: emulates a serial SRAM on the far end of an SPI memory port. The SPI
// pins are oversampled in the clk_i domain. Each SPI clock phase must last at
// least 4 clk_i cycles.
// Optional feature macro: SPI_RAM_MODE_REG_EN adds a mode register with the
// WRMR (0x01) and RDMR (0x05) commands, and adds byte mode.
//
// Ports:
//   clk_i          system clock
//   rst_i          asynchronous active-high reset (storage array is not reset)
//   spi_clk_i      SPI clock from the initiator, idles low
//   spi_select_i   chip select, active low
//   spi_mosi_i     initiator-to-responder data, MSB first
//   spi_miso_o     responder-to-initiator data, MSB first
//   spi_miso_oe_o  high while read data is being driven
//   active_o       high while a selected transaction is in progress

module spi_ram_responder #(
  parameter int ADDR_W      = 16,
  parameter int MEM_ADDR_W  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic spi_clk_i,
  input  logic spi_select_i,
  input  logic spi_mosi_i,
  output logic spi_miso_o,
  output logic spi_miso_oe_o,
  output logic active_o
);

  localparam int DEPTH = 1 << MEM_ADDR_W;
  localparam int CNT_W = $clog2(ADDR_W + 1);
  // Only the low bits of the wire address are kept, so the input shifter
  // needs to hold just a command byte or a storage address.
  localparam int SH_W  = (MEM_ADDR_W > 8) ? MEM_ADDR_W : 8;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_READ, S_WRITE, S_IGNORE
  } state_t;

  // Input synchronizers. The select chain resets high so that leaving reset
  // never looks like a select falling edge.
  logic [SYNC_STAGES-1:0] sclk_sync_q, ssel_sync_q, mosi_sync_q;
  logic sclk_prev_q, ssel_prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      ssel_sync_q <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ssel_prev_q <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk_i};
      ssel_sync_q <= {ssel_sync_q[SYNC_STAGES-2:0], spi_select_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ssel_prev_q <= ssel_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_rise, sclk_fall, sel_fall, sel_rise, mosi_s;
  assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_prev_q;
  assign sel_fall  = ~ssel_sync_q[SYNC_STAGES-1] & ssel_prev_q;
  assign sel_rise  = ssel_sync_q[SYNC_STAGES-1] & ~ssel_prev_q;
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SH_W-2:0]        shin_q, shin_d;
  logic [7:0]             shout_q, shout_d;
  logic [MEM_ADDR_W-1:0]  addr_q, addr_d, addr_inc;
  logic                   rd_flag_q, rd_flag_d;
  logic                   miso_q, miso_d, oe_q, oe_d, active_q, active_d;
  logic [SH_W-1:0]        in_next;
  logic                   mem_we;
  logic                   byte_mode;
  logic [7:0]             mem_q [DEPTH];

  // Shifter contents including the bit being sampled on this rising edge.
  assign in_next  = {shin_q, mosi_s};
  assign addr_inc = addr_q + MEM_ADDR_W'(1);

`ifdef SPI_RAM_MODE_REG_EN
  logic [7:0] mode_q, mode_d;
  logic       rdmr_q, rdmr_d, wrmr_q, wrmr_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q <= 8'h40;
      rdmr_q <= 1'b0;
      wrmr_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      rdmr_q <= rdmr_d;
      wrmr_q <= wrmr_d;
    end
  end

  assign byte_mode = (mode_q[7:6] == 2'b00);
`else
  assign byte_mode = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shin_q    <= '0;
      shout_q   <= '0;
      addr_q    <= '0;
      rd_flag_q <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shin_q    <= shin_d;
      shout_q   <= shout_d;
      addr_q    <= addr_d;
      rd_flag_q <= rd_flag_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      active_q  <= active_d;
    end
  end

  // Storage array: no reset, written only when a full data byte completes.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[addr_q] <= in_next[7:0];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shin_d    = shin_q;
    shout_d   = shout_q;
    addr_d    = addr_q;
    rd_flag_d = rd_flag_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    active_d  = active_q;
    mem_we    = 1'b0;
`ifdef SPI_RAM_MODE_REG_EN
    mode_d    = mode_q;
    rdmr_d    = rdmr_q;
    wrmr_d    = wrmr_q;
`endif
    if (sel_rise || sel_fall) begin
      // Deselect returns to idle; a select fall seen outside idle restarts.
      state_d   = sel_fall ? S_CMD : S_IDLE;
      active_d  = sel_fall;
      cnt_d     = '0;
      rd_flag_d = 1'b0;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
`ifdef SPI_RAM_MODE_REG_EN
      rdmr_d    = 1'b0;
      wrmr_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        S_CMD: begin
          if (sclk_rise) begin
            shin_d = in_next[SH_W-2:0];
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d = '0;
              case (in_next[7:0])
                8'h03: begin state_d = S_ADDR; rd_flag_d = 1'b1; end
                8'h02: begin state_d = S_ADDR; rd_flag_d = 1'b0; end
`ifdef SPI_RAM_MODE_REG_EN
                8'h01: begin state_d = S_WRITE; wrmr_d = 1'b1; end
                8'h05: begin
                  state_d = S_READ;
                  rdmr_d  = 1'b1;
                  shout_d = mode_q;
                  oe_d    = 1'b1;
                end
`endif
                default: state_d = S_IGNORE;
              endcase
            end
          end
        end
        S_ADDR: begin
          if (sclk_rise) begin
            shin_d = in_next[SH_W-2:0];
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ADDR_W - 1)) begin
              cnt_d  = '0;
              addr_d = in_next[MEM_ADDR_W-1:0];
              if (rd_flag_q) begin
                // Preload so the first falling edge can present bit 7.
                shout_d = mem_q[in_next[MEM_ADDR_W-1:0]];
                oe_d    = 1'b1;
                state_d = S_READ;
              end else begin
                state_d = S_WRITE;
              end
            end
          end
        end
        S_READ: begin
          if (sclk_fall) begin
            miso_d  = shout_q[7];
            shout_d = {shout_q[6:0], 1'b0};
          end else if (sclk_rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d = '0;
`ifdef SPI_RAM_MODE_REG_EN
              if (rdmr_q) begin
                shout_d = mode_q;
              end else
`endif
              if (byte_mode) begin
                state_d = S_IGNORE;
                oe_d    = 1'b0;
                miso_d  = 1'b0;
              end else begin
                addr_d  = addr_inc;
                shout_d = mem_q[addr_inc];
              end
            end
          end
        end
        S_WRITE: begin
          if (sclk_rise) begin
            shin_d = in_next[SH_W-2:0];
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d = '0;
`ifdef SPI_RAM_MODE_REG_EN
              if (wrmr_q) begin
                mode_d  = in_next[7:0];
                state_d = S_IGNORE;
              end else
`endif
              begin
                mem_we = 1'b1;
                addr_d = addr_inc;
                if (byte_mode) state_d = S_IGNORE;
              end
            end
          end
        end
        S_IGNORE: begin
          miso_d = 1'b0;
          oe_d   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = oe_q;
  assign active_o      = active_q;

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb/tb_spi_ram_responder.sv - self-checking bench for spi_ram_responder
module tb_spi_ram_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic ssel = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, act;

  int n_cmp = 0;
  int n_fail = 0;

  spi_ram_responder dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .spi_clk_i    (sclk),
    .spi_select_i (ssel),
    .spi_mosi_i   (mosi),
    .spi_miso_o   (miso),
    .spi_miso_oe_o(miso_oe),
    .active_o     (act)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    int          n;
    logic [7:0]  d0;
    logic [7:0]  d1;
  } vec_t;

  vec_t tbl [10];

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_cmp++;
    if (got !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp_v);
    end
  endtask

  task automatic sel();
    ssel = 1'b0;
    wait_clk(8);
  endtask

  task automatic desel();
    sclk = 1'b0;
    wait_clk(4);
    ssel = 1'b1;
    wait_clk(8);
  endtask

  // Sends nbits of tx (MSB first); MISO and OE are sampled just before each rising edge.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits,
                           output logic [7:0] rx, output logic oe_any, output logic oe_all);
    rx = 8'h00;
    oe_any = 1'b0;
    oe_all = 1'b1;
    for (int i = 7; i > 7 - nbits; i--) begin
      mosi = tx[i];
      wait_clk(8);
      rx[i] = miso;
      oe_any = oe_any | miso_oe;
      oe_all = oe_all & miso_oe;
      sclk = 1'b1;
      wait_clk(8);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx,
                      output logic oe_any, output logic oe_all);
    xfer_bits(tx, 8, rx, oe_any, oe_all);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [15:0] addr);
    logic [7:0] r;
    logic a, b;
    xfer(cmd, r, a, b);
    xfer(addr[15:8], r, a, b);
    xfer(addr[7:0], r, a, b);
  endtask

  task automatic do_write(input logic [15:0] addr, input int n, input logic [7:0] d0, input logic [7:0] d1);
    logic [7:0] r;
    logic a, b;
    sel();
    send_hdr(8'h02, addr);
    xfer(d0, r, a, b);
    if (n > 1) xfer(d1, r, a, b);
    desel();
  endtask

  task automatic do_read(input logic [15:0] addr, input int n, output logic [7:0] r0,
                         output logic [7:0] r1, output logic oe0, output logic oe1);
    logic a;
    sel();
    send_hdr(8'h03, addr);
    xfer(8'h00, r0, a, oe0);
    r1 = 8'h00;
    oe1 = 1'b1;
    if (n > 1) xfer(8'h00, r1, a, oe1);
    desel();
  endtask

  initial begin
    logic [7:0] r0, r1, r2, r3;
    logic oe0, oe1, oe_any, oe_all;

    tbl[0] = '{1'b1, 16'h0010, 2, 8'hA5, 8'h3C};
    tbl[1] = '{1'b1, 16'h00FF, 2, 8'h11, 8'h22};
    tbl[2] = '{1'b1, 16'h0021, 1, 8'hEE, 8'h00};
    tbl[3] = '{1'b1, 16'h0040, 2, 8'h5A, 8'hC3};
    tbl[4] = '{1'b0, 16'h0010, 2, 8'hA5, 8'h3C};
    tbl[5] = '{1'b0, 16'h0000, 1, 8'h22, 8'h00};
    tbl[6] = '{1'b0, 16'h00FF, 2, 8'h11, 8'h22};
    tbl[7] = '{1'b0, 16'h01FF, 1, 8'h11, 8'h00};
    tbl[8] = '{1'b0, 16'h0040, 2, 8'h5A, 8'hC3};
    tbl[9] = '{1'b0, 16'h0021, 1, 8'hEE, 8'h00};

    wait_clk(3);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_active", 32'(act), 32'd0);
    rst = 1'b0;
    wait_clk(6);
    chk("idle_active", 32'(act), 32'd0);

`ifdef SPI_RAM_MODE_REG_EN
    sel();
    xfer(8'h05, r0, oe_any, oe_all);
    xfer(8'h00, r0, oe_any, oe0);
    xfer(8'h00, r1, oe_any, oe1);
    desel();
    chk("rdmr_b0", 32'(r0), 32'h40);
    chk("rdmr_b1", 32'(r1), 32'h40);
    chk("rdmr_oe", 32'(oe0 & oe1), 32'd1);
`endif

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].n, tbl[i].d0, tbl[i].d1);
      end else begin
        do_read(tbl[i].addr, tbl[i].n, r0, r1, oe0, oe1);
        chk($sformatf("vec%0d_b0", i), 32'(r0), 32'(tbl[i].d0));
        chk($sformatf("vec%0d_oe", i), 32'(oe0 & oe1), 32'd1);
        if (tbl[i].n > 1) chk($sformatf("vec%0d_b1", i), 32'(r1), 32'(tbl[i].d1));
      end
    end

    // Reset in the middle of a write, then a fresh read of address 0.
    sel();
    send_hdr(8'h02, 16'h0030);
    xfer_bits(8'hFF, 4, r0, oe_any, oe_all);
    @(negedge clk);
    rst = 1'b1;
    ssel = 1'b1;
    sclk = 1'b0;
    wait_clk(3);
    chk("midrst_miso", 32'(miso), 32'd0);
    chk("midrst_oe", 32'(miso_oe), 32'd0);
    chk("midrst_active", 32'(act), 32'd0);
    rst = 1'b0;
    wait_clk(8);
    sel();
    send_hdr(8'h03, 16'h0000);
    xfer(8'h00, r0, oe_any, oe_all);
    chk("postrst_oe", 32'(oe_all), 32'd1);
    chk("postrst_active", 32'(act), 32'd1);
    chk("postrst_data", 32'(r0), 32'h22);
    desel();
    chk("desel_miso", 32'(miso), 32'd0);
    chk("desel_oe", 32'(miso_oe), 32'd0);
    chk("desel_active", 32'(act), 32'd0);

    // Partial trailing byte is discarded.
    sel();
    send_hdr(8'h02, 16'h0020);
    xfer(8'h77, r0, oe_any, oe_all);
    xfer_bits(8'h00, 5, r0, oe_any, oe_all);
    desel();
    do_read(16'h0020, 2, r0, r1, oe0, oe1);
    chk("partial_b0", 32'(r0), 32'h77);
    chk("partial_b1", 32'(r1), 32'hEE);

    // Unknown command: no output enable, no write.
    sel();
    xfer(8'h9F, r0, oe_any, oe_all);
    xfer(8'h02, r1, oe0, oe_all);
    xfer(8'h00, r2, oe1, oe_all);
    xfer(8'h10, r3, oe_all, oe_all);
    chk("unk_oe", 32'(oe_any | oe0 | oe1 | oe_all), 32'd0);
    chk("unk_miso", 32'({r1, r2, r3}), 32'd0);
    desel();
    do_read(16'h0010, 1, r0, r1, oe0, oe1);
    chk("unk_mem", 32'(r0), 32'hA5);

`ifdef SPI_RAM_MODE_REG_EN
    sel();
    xfer(8'h01, r0, oe_any, oe_all);
    xfer(8'h00, r0, oe_any, oe_all);
    desel();
    sel();
    send_hdr(8'h03, 16'h0010);
    xfer(8'h00, r0, oe_any, oe0);
    xfer(8'h00, r1, oe1, oe_all);
    desel();
    chk("bytemode_b0", 32'(r0), 32'hA5);
    chk("bytemode_oe0", 32'(oe0), 32'd1);
    chk("bytemode_oe1", 32'(oe1), 32'd0);
    chk("bytemode_b1", 32'(r1), 32'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
